// File: rtl/zeroriscy_instr_mem_responder_if.sv
// Instruction fetch bus between the core's IF stage (master) and the
// instruction memory responder (slave): req/gnt handshake plus in-order
// rvalid/rdata/err responses.
interface zeroriscy_instr_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/zeroriscy_instr_mem_responder.sv
// Instruction memory responder: grants fetch requests combinationally,
// reads a synchronous single-port SRAM, and returns in-order responses
// RESP_LATENCY cycles after each grant. Out-of-range fetches skip the
// SRAM and come back with err set and zero data.
module zeroriscy_instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  zeroriscy_instr_mem_responder_if.slave instr,
  input  logic                          stall_i,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic [31:0]                   mem_rdata_i
);

  localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

  logic [31:0]             offset;
  logic [31:0]             idx;
  logic                    in_range;
  logic                    grant;
  logic [2:0]              outstanding_q;
  logic [RESP_LATENCY-1:0] vld_q;
  logic [RESP_LATENCY-1:0] err_q;
  logic                    resp_valid;
  logic                    resp_err;
  logic [31:0]             resp_data;

  // Decode the byte address into an SRAM word index and range-check it;
  // the upper index bits must all be zero for the word to exist.
  always_comb begin
    offset   = instr.addr - BASE_ADDR;
    idx      = offset >> 2;
    in_range = (instr.addr >= BASE_ADDR) && ((idx >> ADDR_WIDTH) == 32'd0);
  end

  assign resp_valid = vld_q[RESP_LATENCY-1];
  assign resp_err   = err_q[RESP_LATENCY-1];

  // Grant whenever a slot is free; a retiring response frees its slot in
  // the same cycle. resp_valid is registered, so mem_rdata_i never reaches gnt.
  always_comb begin
    grant      = instr.req & ~stall_i & ((outstanding_q < MAX_OUT) | resp_valid);
    mem_req_o  = grant & in_range;
    mem_addr_o = mem_req_o ? idx[ADDR_WIDTH-1:0] : '0;
  end

  assign instr.gnt = grant;

  // Shift {valid, err} of each granted request towards the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      err_q <= '0;
    end else begin
      vld_q[0] <= grant;
      err_q[0] <= grant & ~in_range;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
      end
    end
  end

  if (RESP_LATENCY == 1) begin : g_direct
    assign resp_data = mem_rdata_i;
  end else begin : g_shift
    logic [31:0] data_q [1:RESP_LATENCY-1];

    // Capture SRAM data behind stage 1 and carry it along with its entry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < RESP_LATENCY; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        data_q[1] <= (vld_q[0] & ~err_q[0]) ? mem_rdata_i : 32'h0;
        for (int i = 2; i < RESP_LATENCY; i++) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign resp_data = data_q[RESP_LATENCY-1];
  end

  assign instr.rvalid = resp_valid;
  assign instr.err    = resp_valid & resp_err;
  assign instr.rdata  = (resp_valid & ~resp_err) ? resp_data : 32'h0;

  // Track granted-but-unanswered requests; a grant and a retirement in the
  // same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else if (grant && !resp_valid) begin
      outstanding_q <= outstanding_q + 3'd1;
    end else if (!grant && resp_valid) begin
      outstanding_q <= outstanding_q - 3'd1;
    end
  end

endmodule

// File: tb/tb_zeroriscy_instr_mem_responder.sv
// Bench for the instruction memory responder. Two configurations share one
// stimulus stream: the defaults (latency 1, base 0, 4K words) and a
// throttled one (latency 3, 2 outstanding, base 0x100, 64 words). Each has
// its own SRAM and a queue-based reference model of pending responses.
module tb_zeroriscy_instr_mem_responder;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s;
  logic [31:0] addr_s;
  logic        stall_s;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One cycle of stimulus, applied on the falling edge.
  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic stall, input logic rst_release);
    @(negedge clk);
    req_s   = req;
    addr_s  = addr;
    stall_s = stall;
    rst_n   = rst_release;
  endtask

  function automatic logic [31:0] pickAddr();
    logic [31:0] edges [8];
    edges = '{32'h0000_00FC, 32'h0000_0100, 32'h0000_01FC, 32'h0000_0200,
              32'h0000_3FFC, 32'h0000_4000, 32'hFFFF_FFFC, 32'h0000_0002};
    case ($urandom % 4)
      0:       return $urandom % 32'h4400;
      1:       return $urandom % 32'h0240;
      2:       return $urandom;
      default: return edges[$urandom % 8] + 32'($urandom % 4);
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int          AW   = (g == 0) ? 12 : 6;
    localparam logic [31:0] BASE = (g == 0) ? 32'h0 : 32'h100;
    localparam int          LAT  = (g == 0) ? 1 : 3;
    localparam int          MAXO = 2;

    zeroriscy_instr_mem_responder_if bus ();

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem [1 << AW];
    resp_t         exp_q [$];
    int            cyc = 0;
    logic          retire;
    logic          exp_gnt;
    logic          exp_inr;
    logic [31:0]   exp_idx;
    logic [31:0]   exp_rdata;
    logic          exp_err;

    assign bus.req  = req_s;
    assign bus.addr = addr_s;

    zeroriscy_instr_mem_responder #(
      .ADDR_WIDTH      (AW),
      .BASE_ADDR       (BASE),
      .RESP_LATENCY    (LAT),
      .MAX_OUTSTANDING (MAXO)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (bus),
      .stall_i     (stall_s),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata)
    );

    initial begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000 ^ 32'(g);
      end
      if (g == 0) mem[5] = 32'hDEAD_BEEF;
    end

    // Synchronous SRAM; returns garbage when not read so ungated data shows up.
    always @(posedge clk) begin
      if (mem_req) mem_rdata <= mem[mem_addr];
      else         mem_rdata <= $urandom;
    end

    // Reference model: a queue of pending responses, each with its due cycle.
    always @(negedge clk) begin
      #2;
      if (!rst_n) exp_q.delete();
      checkOutput($sformatf("cfg%0d outstanding", g), 32'(u_dut.outstanding_q),
                  32'(exp_q.size()));
      retire    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      exp_rdata = retire ? exp_q[0].data : 32'h0;
      exp_err   = retire ? exp_q[0].err  : 1'b0;
      checkOutput($sformatf("cfg%0d rvalid", g), 32'(bus.rvalid), 32'(retire));
      checkOutput($sformatf("cfg%0d rdata", g), bus.rdata, exp_rdata);
      checkOutput($sformatf("cfg%0d err", g), 32'(bus.err), 32'(exp_err));

      exp_gnt = req_s && !stall_s && ((exp_q.size() < MAXO) || retire);
      exp_idx = (addr_s - BASE) / 4;
      exp_inr = (addr_s >= BASE) && (exp_idx < (32'd1 << AW));
      checkOutput($sformatf("cfg%0d gnt", g), 32'(bus.gnt), 32'(exp_gnt));
      checkOutput($sformatf("cfg%0d mem_req", g), 32'(mem_req), 32'(exp_gnt && exp_inr));
      if (exp_gnt && exp_inr)
        checkOutput($sformatf("cfg%0d mem_addr", g), 32'(mem_addr), exp_idx);
      else if (!exp_gnt)
        checkOutput($sformatf("cfg%0d mem_addr idle", g), 32'(mem_addr), 32'h0);

      if (retire) void'(exp_q.pop_front());
      if (exp_gnt && rst_n)
        exp_q.push_back('{cyc + LAT, exp_inr ? mem[exp_idx[AW-1:0]] : 32'h0, !exp_inr});
      cyc++;
    end
  end

  // Directed scenarios first, then a long randomized run with sporadic resets.
  initial begin
    rst_n   = 1'b1;
    req_s   = 1'b0;
    addr_s  = 32'h0;
    stall_s = 1'b0;
    #1 rst_n = 1'b0;

    $display("[TB] reset and grant-during-reset");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] single fetch");
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] stall");
    repeat (3) applyStimulus(1'b1, 32'h18, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] out of range");
    applyStimulus(1'b1, 32'h4000, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10C, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 4) != 0, pickAddr(), ($urandom % 5) == 0,
                    ($urandom % 80) != 0);
    end
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/zeroriscy_instr_mem_responder.md
# zeroriscy_instr_mem_responder

Responder end of the core's instruction fetch interface (req/gnt/rvalid/rdata). It accepts fetch requests from the IF stage prefetch buffer, reads a word-wide synchronous single-port instruction SRAM, and returns in-order read responses after a fixed, parameterized latency. It sits between the core's `instr_*` port and the instruction SRAM macro in the SoC/testbench, and flags out-of-range fetches.

## Interface
- `ADDR_WIDTH`, default 12: SRAM word-address width; the SRAM is 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of SRAM word 0; must be 4-byte aligned.
- `RESP_LATENCY`, default 1: cycles from the grant to `instr_rvalid_o`; legal range 1..4.
- `MAX_OUTSTANDING`, default 2: maximum number of granted, not-yet-responded requests; legal range 1..4.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_req_i` input 1: fetch request from the core.
- `instr_addr_i` input 32: fetch byte address; bits [1:0] are ignored.
- `instr_gnt_o` output 1: request accepted this cycle.
- `instr_rvalid_o` output 1: response valid, for one cycle per granted request.
- `instr_rdata_o` output 32: response data.
- `instr_err_o` output 1: response is for an out-of-range address; qualified by `instr_rvalid_o`.
- `stall_i` input 1: withholds the grant while high (bench/arbiter hook).
- `mem_req_o` output 1: SRAM read enable.
- `mem_addr_o` output ADDR_WIDTH: SRAM word address.
- `mem_rdata_i` input 32: SRAM read data, valid in the cycle after `mem_req_o`.

## Operation
- Word index: `idx = (instr_addr_i - BASE_ADDR) >> 2`, computed with 32-bit wraparound subtraction. The request is in range iff `instr_addr_i >= BASE_ADDR` and `idx < 2^ADDR_WIDTH`.
- Grant is combinational. `instr_gnt_o = instr_req_i & ~stall_i & (outstanding_q < MAX_OUTSTANDING | instr_rvalid_o)`. A response retiring in a cycle frees its slot in that same cycle.
- On a grant with an in-range address: `mem_req_o = 1` and `mem_addr_o = idx[ADDR_WIDTH-1:0]` in the same cycle.
- On a grant with an out-of-range address: `mem_req_o = 0` and no SRAM access occurs. The response carries `instr_err_o = 1` and `instr_rdata_o = 32'h0`.
- When there is no grant, `mem_req_o = 0` and `mem_addr_o = 0`.
- Response pipeline:
  - It is a shift register of RESP_LATENCY stages, each holding {valid, err}.
  - SRAM data is captured at stage 1. For stages beyond the first, data shifts along with the entry.
  - Stage RESP_LATENCY drives the outputs. When RESP_LATENCY = 1, `instr_rdata_o` comes directly from `mem_rdata_i`, gated.
- `outstanding_q`:
  - Width is 3 bits.
  - It increments on a grant and decrements on `instr_rvalid_o`. When both happen in the same cycle it holds.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Responses are strictly in grant order. No request is dropped, and no response is duplicated.
- Output masking: `instr_rdata_o = 0` and `instr_err_o = 0` whenever `instr_rvalid_o = 0`.
- `stall_i` affects only new grants. In-flight responses still complete on schedule.
- Reset values: `instr_gnt_o = 0`, `instr_rvalid_o = 0`, `instr_rdata_o = 0`, `instr_err_o = 0`, `mem_req_o = 0`, `mem_addr_o = 0`, `outstanding_q = 0`, and all pipeline valid bits = 0.
  - The grant, `mem_req_o` and `mem_addr_o` are combinational. During reset they are 0 only because there is no grant. `instr_gnt_o` still follows `instr_req_i` while `rst_n` is low.
- Reset mid-operation: all in-flight entries are discarded. No `instr_rvalid_o` pulse appears for any request granted before the reset.

## Timing
- Grant latency is 0 cycles: with a free slot and `stall_i = 0`, the grant is in the same cycle as the request.
- A request granted in cycle N gets `instr_rvalid_o` in cycle N + RESP_LATENCY.
- Throughput:
  - One grant per cycle when MAX_OUTSTANDING >= RESP_LATENCY.
  - Otherwise at most MAX_OUTSTANDING grants per RESP_LATENCY cycles.
  - With the defaults (latency 1, 2 outstanding) the port streams one word per cycle.
- The address is sampled only in the grant cycle. Changes to `instr_addr_i` while `instr_req_i` is high and ungranted have no effect until the grant.
- There is no combinational path from `mem_rdata_i` to `instr_gnt_o`.

## Test plan
- **Single fetch:** defaults, `BASE_ADDR = 0`, SRAM word 5 = 32'hDEAD_BEEF. Request at addr 32'h14 in cycle N -> `gnt` in N, `mem_addr_o = 5` in N, `rvalid` in N+1 with `rdata = 32'hDEAD_BEEF` and `err = 0`.
- **Streaming:** 8 back-to-back requests at addr 0x0, 0x4, ..., 0x1C -> 8 consecutive grants and 8 consecutive `rvalid` cycles, carrying words 0..7 in order.
- **Stall:** `stall_i = 1` for 3 cycles while the request is held -> no grant during those 3 cycles; grant in the first cycle `stall_i = 0`; response 1 cycle later.
- **Out of range:** `ADDR_WIDTH = 12`, request at 32'h4000 -> `gnt = 1`, `mem_req_o = 0`, then `rvalid = 1`, `err = 1`, `rdata = 0`.
- **Throttle:** `RESP_LATENCY = 3`, `MAX_OUTSTANDING = 2`, continuous requests -> grants in cycles 0, 1, 3, 4, 6, ...; rvalid in cycles 3, 4, 6, 7, ...; `outstanding_q` never exceeds 2.
- **Reset mid-flight:** `RESP_LATENCY = 3`, two grants, then `rst_n` low for 1 cycle -> no `rvalid` afterwards; `outstanding_q = 0`; the next request is granted immediately.
